// File: rtl/keypad_scanner_pkg.sv
// Shared keypad constants and small helpers for the scanner.
package keypad_scanner_pkg;

  localparam int unsigned KEYPAD_ROWS = 4;
  localparam int unsigned KEYPAD_COLS = 4;
  localparam int unsigned ROW_W       = 2;
  localparam int unsigned COL_W       = 2;
  localparam int unsigned CODE_W      = ROW_W + COL_W;

  // key_code packing is {row[1:0], col[1:0]}; r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
  localparam logic [CODE_W-1:0] KEY_0    = 4'b1101;
  localparam logic [CODE_W-1:0] KEY_ASS  = 4'b1100;
  localparam logic [CODE_W-1:0] KEY_HASH = 4'b1110;
  localparam logic [CODE_W-1:0] KEY_D    = 4'b1111;

  // Index of the lowest-numbered active-low row; 0 when none is low.
  function automatic logic [ROW_W-1:0] lowest_low_row(input logic [KEYPAD_ROWS-1:0] rows);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = int'(KEYPAD_ROWS) - 1; i >= 0; i--) begin
      if (!rows[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

  // Active-low one-hot column drive for a column index.
  function automatic logic [KEYPAD_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
    return ~(KEYPAD_COLS'(1) << idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous input pins.
module sync_2ff #(
  parameter int unsigned     WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages; reset value chosen to match the idle pin level.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce, one key event per press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic                   clk,
  input  logic                   reset_in,
  input  logic [KEYPAD_ROWS-1:0] row_in,
  output logic [KEYPAD_COLS-1:0] col_out,
  output logic [CODE_W-1:0]      key_code,
  output logic                   data_ready
);

  localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_EMIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [COL_W-1:0]    col_idx, col_idx_n;
  logic [ROW_W-1:0]    row_lat, row_lat_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CODE_W-1:0]   key_code_n;
  logic                data_ready_n;
  logic [KEYPAD_ROWS-1:0] rs;

  sync_2ff #(
    .WIDTH     (KEYPAD_ROWS),
    .RESET_VAL ('1)
  ) u_row_sync (
    .clk      (clk),
    .reset_in (reset_in),
    .d        (row_in),
    .q        (rs)
  );

  // State, shared counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state      <= ST_SCAN;
      col_idx    <= '0;
      col_out    <= col_drive('0);
      row_lat    <= '0;
      cnt        <= '0;
      key_code   <= '0;
      data_ready <= 1'b0;
    end else begin
      state      <= state_n;
      col_idx    <= col_idx_n;
      col_out    <= col_drive(col_idx_n);
      row_lat    <= row_lat_n;
      cnt        <= cnt_n;
      key_code   <= key_code_n;
      data_ready <= data_ready_n;
    end
  end

  // Scan / debounce-press / emit / debounce-release sequencing.
  always_comb begin
    state_n      = state;
    col_idx_n    = col_idx;
    row_lat_n    = row_lat;
    cnt_n        = cnt;
    key_code_n   = key_code;
    data_ready_n = 1'b0;

    case (state)
      ST_SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_n = '0;
          if (rs != '1) begin
            row_lat_n = lowest_low_row(rs);
            state_n   = ST_PRESS;
          end else begin
            col_idx_n = col_idx + COL_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_PRESS: begin
        if (rs[row_lat]) begin
          // Bounce: retry the same column from a fresh scan window.
          state_n = ST_SCAN;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n      = ST_EMIT;
          cnt_n        = '0;
          key_code_n   = {row_lat, col_idx};
          data_ready_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_EMIT: begin
        state_n = ST_RELEASE;
        cnt_n   = '0;
      end

      ST_RELEASE: begin
        if (!rs[row_lat]) begin
          cnt_n = '0;
        end else if (cnt == DEB_LAST) begin
          state_n   = ST_SCAN;
          col_idx_n = col_idx + COL_W'(1);
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = ST_SCAN;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  logic       clk;
  logic       reset_in;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       data_ready;

  logic [15:0] keys;        // bit {r,c} set = key (r,c) held down
  int          checks;
  int          errors;
  int          pulse_cnt;
  logic [3:0]  last_code;

  keypad_scanner #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_code   (key_code),
    .data_ready (data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r pulled low when any held key in row r sits on a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Count every cycle data_ready is high and remember the code shown then.
  always @(posedge clk) begin
    if (data_ready) begin
      pulse_cnt <= pulse_cnt + 1;
      last_code <= key_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input string tag, input int start, input int budget);
    int n;
    n = 0;
    while (pulse_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(pulse_cnt != start), 32'd1);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] target, input int budget);
    int n;
    n = 0;
    while (col_out !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(col_out), 32'(target));
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    keys[r*4 + c] = v;
  endtask

  initial begin
    logic [3:0] rot [4];
    int         base;
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    last_code = 4'h0;
    keys      = '0;
    reset_in  = 1'b1;
    rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;

    // Reset state, no keys.
    repeat (3) @(negedge clk);
    chk("reset_col_out", 32'(col_out), 32'h0000000E);
    chk("reset_key_code", 32'(key_code), 32'h0);
    chk("reset_data_ready", 32'(data_ready), 32'h0);
    reset_in = 1'b0;

    // Idle rotation: one column step every 4 clocks.
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      chk("rotate", 32'(col_out), 32'(rot[i]));
    end

    // Hold '5': one pulse, column frozen until 8 released cycles.
    set_key(1, 1, 1'b1);
    wait_pulse("press5_pulse", 0, 100);
    chk("press5_code", 32'(key_code), 32'h5);
    repeat (20) @(negedge clk);
    chk("press5_single", 32'(pulse_cnt), 32'd1);
    chk("press5_col_frozen", 32'(col_out), 32'hD);
    set_key(1, 1, 1'b0);
    repeat (9) @(negedge clk);
    chk("release5_hold", 32'(col_out), 32'hD);
    @(negedge clk);
    chk("release5_step", 32'(col_out), 32'hB);

    // Glitch '#' for 5 cycles: enters PRESS then bounces back to column 2.
    set_key(3, 2, 1'b1);
    repeat (5) @(negedge clk);
    set_key(3, 2, 1'b0);
    repeat (3) @(negedge clk);
    chk("glitch_col", 32'(col_out), 32'hB);
    chk("glitch_no_pulse", 32'(pulse_cnt), 32'd1);
    repeat (3) @(negedge clk);
    chk("glitch_rescan_hold", 32'(col_out), 32'hB);
    @(negedge clk);
    chk("glitch_rescan_step", 32'(col_out), 32'h7);

    // Hold '0' for 1000 clocks, then a bouncy release.
    set_key(3, 1, 1'b1);
    repeat (1000) @(negedge clk);
    chk("key0_pulse", 32'(pulse_cnt), 32'd2);
    chk("key0_code", 32'(key_code), 32'(KEY_0));
    for (int b = 0; b < 3; b++) begin
      set_key(3, 1, 1'b0);
      repeat (4) @(negedge clk);
      set_key(3, 1, 1'b1);
      repeat (4) @(negedge clk);
    end
    chk("key0_bounce_col", 32'(col_out), 32'hD);
    set_key(3, 1, 1'b0);
    repeat (30) @(negedge clk);
    chk("key0_single", 32'(pulse_cnt), 32'd2);
    chk("key0_last_code", 32'(last_code), 32'(KEY_0));

    // '7' and '*' together on column 0: lowest row wins.
    set_key(2, 0, 1'b1);
    set_key(3, 0, 1'b1);
    wait_pulse("multi_pulse", 2, 100);
    chk("multi_code", 32'(key_code), 32'h8);
    set_key(2, 0, 1'b0);
    set_key(3, 0, 1'b0);
    repeat (30) @(negedge clk);
    chk("multi_single", 32'(pulse_cnt), 32'd3);

    // Reset in the middle of debouncing 'A'.
    base = pulse_cnt;
    wait_col("a_wait_col3", 4'b0111, 40);
    set_key(0, 3, 1'b1);
    repeat (5) @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    chk("rst_col_out", 32'(col_out), 32'hE);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_data_ready", 32'(data_ready), 32'h0);
    set_key(0, 3, 1'b0);
    reset_in = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_no_pulse", 32'(pulse_cnt), 32'(base));
    chk("rst_code_held", 32'(key_code), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
